// File: rtl/mac_burst_acc_if.sv
// Operand/result bundle between a streaming source, mac_burst_acc and the result consumer.
// The master side drives operands and burst control; the slave side is the MAC engine.
interface mac_burst_acc_if #(
  parameter int IN_W  = 128,
  parameter int ACC_W = 512,
  parameter int LEN_W = 16
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             sat_en;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  a_in;
  logic [IN_W-1:0]  b_in;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             busy;
  logic             ovf;

  modport master (
    output start, len, sat_en, in_valid, a_in, b_in,
    input  in_ready, acc_out, out_valid, busy, ovf
  );

  modport slave (
    input  start, len, sat_en, in_valid, a_in, b_in,
    output in_ready, acc_out, out_valid, busy, ovf
  );
endinterface

// File: rtl/mac_burst_acc.sv
// Burst multiply-accumulate: a two-stage multiply/add pipeline summing len operand
// products, with optional saturation, a sticky overflow flag and a result strobe.
//
// state | meaning
// IDLE  | waiting for start; no operands accepted
// RUN   | accepting operand pairs until remaining reaches zero
// DRAIN | last pair accepted; waiting for the pipeline to empty
// DONE  | one-cycle result strobe, then back to IDLE
module mac_burst_acc #(
  parameter int IN_W  = 128,
  parameter int ACC_W = 512,
  parameter int LEN_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  mac_burst_acc_if.slave bus
);

  if (ACC_W < 2 * IN_W) begin : g_bad_width
    $error("mac_burst_acc: ACC_W must be at least 2*IN_W");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   remaining;
  logic               sat_lat;
  logic               p1_valid, p2_valid;
  logic [2*IN_W-1:0]  p1_prod;
  logic [2*IN_W-1:0]  prod;
  logic [ACC_W-1:0]   acc;
  logic               ovf_q;
  logic [ACC_W:0]     sum;
  logic               xfer;
  logic               start_ok;

  assign xfer     = bus.in_valid && (state_q == RUN);
  assign start_ok = bus.start && (state_q == IDLE);
  assign prod     = {{IN_W{1'b0}}, bus.a_in} * {{IN_W{1'b0}}, bus.b_in};
  // One extra bit on the sum exposes the carry out of the accumulator.
  assign sum      = {1'b0, acc} + {{(ACC_W + 1 - 2 * IN_W){1'b0}}, p1_prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.len == '0) ? DONE : RUN;
      RUN:     if (xfer && remaining == LEN_W'(1)) state_d = DRAIN;
      DRAIN:   if (!p1_valid && !p2_valid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      sat_lat   <= 1'b0;
      p1_valid  <= 1'b0;
      p1_prod   <= '0;
      p2_valid  <= 1'b0;
      acc       <= '0;
      ovf_q     <= 1'b0;
    end else begin
      p1_valid <= xfer;
      if (xfer) p1_prod <= prod;
      p2_valid <= p1_valid;

      if (start_ok) begin
        remaining <= bus.len;
        sat_lat   <= bus.sat_en;
      end else if (xfer) begin
        remaining <= remaining - LEN_W'(1);
      end

      if (start_ok) begin
        acc   <= '0;
        ovf_q <= 1'b0;
      end else if (p1_valid) begin
        if (sum[ACC_W]) begin
          ovf_q <= 1'b1;
          acc   <= sat_lat ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        end else begin
          acc <= sum[ACC_W-1:0];
        end
      end
    end
  end

  assign bus.in_ready  = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.acc_out   = acc;
  assign bus.ovf       = ovf_q;

endmodule
